// File: rtl/ultrasonic_scanner.sv
// Round-robin multi-channel ultrasonic ranging controller: fires one sensor
// trigger per slot, measures the echo-high width and reports one result per slot.
module ultrasonic_scanner #(
  parameter int CHANNELS    = 2,
  parameter int CH_W        = 1,
  parameter int TRIG_CYCLES = 250,
  parameter int SLOT_CYCLES = 1500000,
  parameter int CNT_W       = 21
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] echo,
  output logic [CHANNELS-1:0] trig,
  output logic [CNT_W-1:0]    echo_width,
  output logic [CH_W-1:0]     echo_ch,
  output logic                echo_timeout,
  output logic                echo_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [CH_W-1:0]  CH_ONE    = CH_W'(1);

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic                es, es_prev_q;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    t_q, t_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                issued_q, issued_d;
  logic [CHANNELS-1:0] trig_q, trig_d;
  logic [CNT_W-1:0]    width_q, width_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic                timeout_q, timeout_d;
  logic                valid_q, valid_d;

  assign es = sync2_q[ch_q];

  always_comb begin
    state_d   = state_q;
    t_d       = (state_q == S_IDLE) ? '0 : t_q + CNT_ONE;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    issued_d  = issued_q;
    trig_d    = '0;
    width_d   = width_q;
    out_ch_d  = out_ch_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        issued_d = 1'b0;
        cnt_d    = '0;
        if (enable) state_d = S_TRIG;
      end
      S_TRIG: begin
        trig_d[ch_q] = 1'b1;
        if (t_q == TRIG_LAST) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        // Only a genuine 0->1 transition starts a measurement.
        if (es && !es_prev_q) begin
          state_d = S_MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      S_MEASURE: begin
        if (es) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end else begin
          width_d   = cnt_q;
          timeout_d = 1'b0;
          out_ch_d  = ch_q;
          valid_d   = 1'b1;
          issued_d  = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Slot end overrides; a measurement finishing this same cycle already set issued_d.
    if (state_q != S_IDLE && t_q == SLOT_LAST) begin
      if (!issued_d) begin
        width_d   = '0;
        timeout_d = 1'b1;
        out_ch_d  = ch_q;
        valid_d   = 1'b1;
      end
      ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_ONE;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      es_prev_q <= 1'b0;
      state_q   <= S_IDLE;
      t_q       <= '0;
      cnt_q     <= '0;
      ch_q      <= '0;
      issued_q  <= 1'b0;
      trig_q    <= '0;
      width_q   <= '0;
      out_ch_q  <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= echo;
      sync2_q   <= sync1_q;
      es_prev_q <= es;
      state_q   <= state_d;
      t_q       <= t_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      issued_q  <= issued_d;
      trig_q    <= trig_d;
      width_q   <= width_d;
      out_ch_q  <= out_ch_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
    end
  end

  assign trig         = trig_q;
  assign echo_width   = width_q;
  assign echo_ch      = out_ch_q;
  assign echo_timeout = timeout_q;
  assign echo_valid   = valid_q;

endmodule

// File: tb/tb_ultrasonic_scanner.sv
// Self-checking bench for ultrasonic_scanner: directed slot table, randomized
// slots against a slot-level reference model, and hand-written corner sequences.
module tb_ultrasonic_scanner;
  localparam int CHANNELS    = 2;
  localparam int CH_W        = 1;
  localparam int TRIG_CYCLES = 4;
  localparam int SLOT_CYCLES = 64;
  localparam int CNT_W       = 8;

  logic                clk_in = 1'b0;
  logic                rst_n  = 1'b1;
  logic                enable = 1'b0;
  logic [CHANNELS-1:0] echo   = '0;
  logic [CHANNELS-1:0] trig;
  logic [CNT_W-1:0]    echo_width;
  logic [CH_W-1:0]     echo_ch;
  logic                echo_timeout;
  logic                echo_valid;

  ultrasonic_scanner #(
    .CHANNELS(CHANNELS), .CH_W(CH_W), .TRIG_CYCLES(TRIG_CYCLES),
    .SLOT_CYCLES(SLOT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .echo(echo), .trig(trig),
    .echo_width(echo_width), .echo_ch(echo_ch), .echo_timeout(echo_timeout),
    .echo_valid(echo_valid)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ch = 0;
  int last_tr  = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Slot-level reference: a pulse of len clocks starting s clocks after the
  // trigger falls yields width=len, reported 3 clocks after the raw fall,
  // provided that report lands no later than the slot-end report at offset 63.
  function automatic void model_slot(input int s, input int len, input bit pre_high,
                                     output int w, output bit to, output int rel);
    int fall_rel;
    fall_rel = TRIG_CYCLES + s + len;
    if (pre_high || s < 0 || fall_rel + 3 > SLOT_CYCLES - 1) begin
      w = 0; to = 1'b1; rel = SLOT_CYCLES - 1;
    end else begin
      w = len; to = 1'b0; rel = fall_rel + 3;
    end
  endfunction

  task automatic run_slot(input string tag, input int exp_ch, input int s, input int len,
                          input bit pre_high, input int exp_w, input bit exp_to,
                          input int exp_rel, input int drop_rel, input bit chk_period,
                          input int max_wait);
    int waited = 0;
    int tr;
    int nvalid = 0;
    int vrel   = -1;
    int trig_hi = 0;
    logic [CNT_W-1:0] vw = '0;
    logic [CH_W-1:0]  vch = '0;
    logic             vto = 1'b0;
    logic [CHANNELS-1:0] exp_trig;
    exp_trig = '0;
    exp_trig[exp_ch] = 1'b1;
    if (pre_high) echo[exp_ch] = 1'b1;
    while (trig == '0 && waited < 300) begin
      @(posedge clk_in); #1;
      waited++;
    end
    if (trig == '0) begin
      check({tag, " trigger seen"}, 0, 1);
      return;
    end
    if (max_wait > 0) check({tag, " trigger latency ok"}, waited <= max_wait, 1);
    tr = cyc;
    if (chk_period && last_tr >= 0) check({tag, " trigger period"}, tr - last_tr, SLOT_CYCLES + 1);
    last_tr = tr;
    check({tag, " trigger channel"}, trig, exp_trig);
    for (int rel = 0; rel <= SLOT_CYCLES; rel++) begin
      if (rel > 0) begin
        @(posedge clk_in); #1;
      end
      if (rel == drop_rel) enable = 1'b0;
      if (pre_high) echo[exp_ch] = (rel < SLOT_CYCLES - 2);
      else if (s >= 0) echo[exp_ch] = (rel >= TRIG_CYCLES + s) && (rel < TRIG_CYCLES + s + len);
      if (trig != '0) trig_hi++;
      if (echo_valid) begin
        nvalid++;
        vrel = rel; vw = echo_width; vch = echo_ch; vto = echo_timeout;
      end
    end
    echo[exp_ch] = 1'b0;
    check({tag, " trigger width"}, trig_hi, TRIG_CYCLES);
    check({tag, " valid count"}, nvalid, 1);
    check({tag, " valid offset"}, vrel, exp_rel);
    check({tag, " width"}, vw, exp_w);
    check({tag, " channel"}, vch, exp_ch);
    check({tag, " timeout"}, vto, exp_to);
    $display("slot %s: ch=%0d width=%0d timeout=%0d at offset %0d (expected ch=%0d width=%0d timeout=%0d offset %0d)",
             tag, vch, vw, vto, vrel, exp_ch, exp_w, exp_to, exp_rel);
  endtask

  // Result outputs may only move together with echo_valid; trig is never multi-hot.
  logic [CNT_W-1:0] pw = '0;
  logic [CH_W-1:0]  pc = '0;
  logic             pt = 1'b0;
  logic             prst = 1'b0;
  always @(negedge clk_in) begin
    if (rst_n && prst) begin
      check("trig onehot", $countones(trig) <= 1, 1);
      if (!echo_valid) check("result held", {echo_width, echo_ch, echo_timeout}, {pw, pc, pt});
    end
    pw = echo_width; pc = echo_ch; pt = echo_timeout; prst = rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int s; int len; bit pre_high; int exp_ch; int exp_w; bit exp_to; int exp_rel;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int w, rel, hi, waited;
    bit to, none;
    int s, len;
    logic [CHANNELS-1:0] exp_trig;

    vecs[0] = '{5, 20, 1'b0, 0, 20, 1'b0, 32};
    vecs[1] = '{-1, 0, 1'b0, 1, 0, 1'b1, 63};
    vecs[2] = '{3, 1, 1'b0, 0, 1, 1'b0, 11};
    vecs[3] = '{10, 46, 1'b0, 1, 46, 1'b0, 63};
    vecs[4] = '{10, 47, 1'b0, 0, 0, 1'b1, 63};
    vecs[5] = '{1, 30, 1'b0, 1, 30, 1'b0, 38};
    vecs[6] = '{-1, 0, 1'b1, 0, 0, 1'b1, 63};

    enable = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset trig", trig, 0);
    check("reset echo_valid", echo_valid, 0);
    check("reset echo_width", echo_width, 0);
    check("reset echo_ch", echo_ch, 0);
    check("reset echo_timeout", echo_timeout, 0);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rst_n = 1'b1;

    model_ch = 0;
    foreach (vecs[i]) begin
      run_slot($sformatf("vec%0d", i), vecs[i].exp_ch, vecs[i].s, vecs[i].len, vecs[i].pre_high,
               vecs[i].exp_w, vecs[i].exp_to, vecs[i].exp_rel, -1, i > 0, (i == 0) ? 3 : 0);
      model_ch = (model_ch + 1) % CHANNELS;
    end

    for (int i = 0; i < 12; i++) begin
      none = ($urandom_range(0, 3) == 0);
      s    = none ? -1 : int'($urandom_range(1, 20));
      len  = $urandom_range(1, 45);
      model_slot(s, len, 1'b0, w, to, rel);
      run_slot($sformatf("rnd%0d", i), model_ch, s, len, 1'b0, w, to, rel, -1, 1'b1, 0);
      model_ch = (model_ch + 1) % CHANNELS;
    end

    model_slot(5, 10, 1'b0, w, to, rel);
    run_slot("en_drop", model_ch, 5, 10, 1'b0, w, to, rel, 20, 1'b1, 0);
    model_ch = (model_ch + 1) % CHANNELS;
    hi = 0;
    repeat (100) begin
      @(posedge clk_in); #1;
      if (trig != '0) hi++;
    end
    check("no trig while disabled", hi, 0);
    enable = 1'b1;
    model_slot(2, 8, 1'b0, w, to, rel);
    run_slot("en_resume", model_ch, 2, 8, 1'b0, w, to, rel, -1, 1'b0, 3);
    model_ch = (model_ch + 1) % CHANNELS;

    waited = 0;
    while (trig == '0 && waited < 300) begin
      @(posedge clk_in); #1;
      waited++;
    end
    exp_trig = '0;
    exp_trig[model_ch] = 1'b1;
    check("pre-reset trigger channel", trig, exp_trig);
    for (int r = 1; r <= 20; r++) begin
      @(posedge clk_in); #1;
      echo[model_ch] = (r >= 9);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {trig, echo_valid, echo_width, echo_ch, echo_timeout}, 0);
    $display("reset asserted mid-measurement: trig=%0d valid=%0d width=%0d ch=%0d timeout=%0d",
             trig, echo_valid, echo_width, echo_ch, echo_timeout);
    echo = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rst_n = 1'b1;
    model_ch = 0;
    last_tr  = -1;
    model_slot(5, 12, 1'b0, w, to, rel);
    run_slot("post_reset", model_ch, 5, 12, 1'b0, w, to, rel, -1, 1'b0, 3);
    model_ch = (model_ch + 1) % CHANNELS;
    model_slot(7, 25, 1'b0, w, to, rel);
    run_slot("post_reset2", model_ch, 7, 25, 1'b0, w, to, rel, -1, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
